// File: rtl/uart_tx_core_if.sv
// Handshake and line signals between the UART register block (master) and the transmitter core (slave).
interface uart_tx_core_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  tx_valid;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  parity_en;
   logic                  parity_odd;
   logic                  tx_ready;
   logic                  tx_serial;
   logic                  tx_busy;
   logic                  tx_done;

   modport master (
      output tx_valid, tx_data, parity_en, parity_odd,
      input  tx_ready, tx_serial, tx_busy, tx_done
   );

   modport slave (
      input  tx_valid, tx_data, parity_en, parity_odd,
      output tx_ready, tx_serial, tx_busy, tx_done
   );
endinterface

// File: rtl/uart_tx_core.sv
// Parametrised UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_core #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int STOP_BITS    = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   uart_tx_core_if.slave     bus
);
   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
   localparam logic [BAUD_W-1:0] BAUD_MAX  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
   localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [BAUD_W-1:0]     r_baud;
   logic [BIT_W-1:0]      r_bit;
   logic                  r_stop;
   logic                  r_serial;
   logic                  r_busy;
   logic                  r_done;
   logic                  w_tick;

`ifdef UART_TX_PARITY_EN
   // Parity is resolved at handshake so the shifting word need not be kept.
   logic                  r_par_en;
   logic                  r_par_bit;
`else
   logic                  w_unused;
   assign w_unused = bus.parity_en ^ bus.parity_odd;
`endif

   assign w_tick        = (r_baud == BAUD_MAX);
   assign bus.tx_ready  = (r_state == IDLE) && i_rst_n;
   assign bus.tx_serial = r_serial;
   assign bus.tx_busy   = r_busy;
   assign bus.tx_done   = r_done;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state  <= IDLE;
         r_shift  <= '0;
         r_baud   <= '0;
         r_bit    <= '0;
         r_stop   <= 1'b0;
         r_serial <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par_en  <= 1'b0;
         r_par_bit <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         r_baud <= (r_state == IDLE || w_tick) ? '0 : r_baud + BAUD_W'(1);
         case (r_state)
            IDLE: begin
               if (bus.tx_valid) begin
                  r_shift  <= bus.tx_data;
                  r_bit    <= '0;
                  r_stop   <= 1'b0;
                  r_serial <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= START;
`ifdef UART_TX_PARITY_EN
                  r_par_en  <= bus.parity_en;
                  r_par_bit <= ^bus.tx_data ^ bus.parity_odd;
`endif
               end
            end
            START: begin
               if (w_tick) begin
                  r_serial <= r_shift[0];
                  r_state  <= DATA;
               end
            end
            DATA: begin
               if (w_tick) begin
                  if (r_bit == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                     if (r_par_en) begin
                        r_serial <= r_par_bit;
                        r_state  <= PARITY;
                     end else begin
                        r_serial <= 1'b1;
                        r_state  <= STOP;
                     end
`else
                     r_serial <= 1'b1;
                     r_state  <= STOP;
`endif
                  end else begin
                     r_bit    <= r_bit + BIT_W'(1);
                     r_shift  <= r_shift >> 1;
                     r_serial <= r_shift[1];
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
               if (w_tick) begin
                  r_serial <= 1'b1;
                  r_state  <= STOP;
               end
            end
`endif
            STOP: begin
               if (w_tick) begin
                  if (r_stop == STOP_LAST) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= IDLE;
                  end else begin
                     r_stop <= 1'b1;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
